// File: rtl/lighthouse_pkg.sv
// Shared constants and helpers for the lighthouse sweep capture path.
package lighthouse_pkg;

  localparam int LH_WIDTH               = 24;
  localparam int LH_ID_W                = 2;
  localparam int LH_REC_W               = LH_ID_W + 3 * LH_WIDTH;
  localparam int CLOCKS_PER_MICROSECOND = 48;

  // Record layout {id, sync0, sync1, sweep}, LSB offsets
  localparam int LH_SWEEP_LSB = 0;
  localparam int LH_SYNC1_LSB = LH_WIDTH;
  localparam int LH_SYNC0_LSB = 2 * LH_WIDTH;
  localparam int LH_ID_LSB    = 3 * LH_WIDTH;

  // (base + off) mod n, valid for base < n and off <= n
  function automatic logic [LH_ID_W-1:0] lh_rr_idx(input int unsigned base,
                                                   input int unsigned off,
                                                   input int unsigned n);
    int unsigned s;
    s = base + off;
    if (s >= n) begin
      s = s - n;
    end else begin
      s = s;
    end
    return s[LH_ID_W-1:0];
  endfunction

endpackage

// File: rtl/lh_rr_arbiter.sv
// Round-robin scan: first request at or after rr_ptr_i wins. Pure combinational;
// the pointer register lives in the parent.
module lh_rr_arbiter
  import lighthouse_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]       req_i,
  input  logic [LH_ID_W-1:0] rr_ptr_i,
  output logic [N-1:0]       gnt_o,
  output logic [LH_ID_W-1:0] gnt_idx_o,
  output logic               any_gnt_o
);

  logic [LH_ID_W-1:0] idx_s;

  // Scan requests starting from the pointer, wrapping once
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx_s     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_s = lh_rr_idx(32'(rr_ptr_i), k, N);
      if (!any_gnt_o && req_i[idx_s]) begin
        gnt_o[idx_s] = 1'b1;
        gnt_idx_o    = idx_s;
        any_gnt_o    = 1'b1;
      end else begin
        any_gnt_o = any_gnt_o;
      end
    end
  end

endmodule

// File: rtl/lighthouse_arbiter.sv
// Merges per-sensor sweep records into one valid/ready record stream.
// Optional per-channel saturating drop counters: LIGHTHOUSE_ARB_DROP_COUNT_EN.
module lighthouse_arbiter
  import lighthouse_pkg::*;
#(
  parameter int NUM_SENSORS = 3,
  parameter int WIDTH       = LH_WIDTH
) (
  input  logic                             clk_48,
  input  logic                             reset,
  input  logic [NUM_SENSORS*WIDTH-1:0]     sync0,
  input  logic [NUM_SENSORS*WIDTH-1:0]     sync1,
  input  logic [NUM_SENSORS*WIDTH-1:0]     sweep,
  input  logic [NUM_SENSORS-1:0]           sweep_strobe,
  output logic [LH_ID_W+3*WIDTH-1:0]       out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_SENSORS-1:0]           overflow,
  output logic [NUM_SENSORS*8-1:0]         drop_count
);

  localparam int SLOT_W = 3 * WIDTH;
  localparam int REC_W  = LH_ID_W + SLOT_W;

  logic [SLOT_W-1:0]      slot_q [NUM_SENSORS];
  logic [SLOT_W-1:0]      slot_d [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] slot_valid_q, slot_valid_d;
  logic [NUM_SENSORS-1:0] overflow_q, overflow_d;
  logic [NUM_SENSORS-1:0] drop_s;
  logic [REC_W-1:0]       out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [LH_ID_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                   grant_en_s;
  logic [NUM_SENSORS-1:0] req_s;
  logic [NUM_SENSORS-1:0] gnt_s;
  logic [LH_ID_W-1:0]     gnt_idx_s;
  logic                   any_gnt_s;

  // The output register may take a new record when empty or being drained
  assign grant_en_s = !out_valid_q || out_ready;
  assign req_s      = slot_valid_q & {NUM_SENSORS{grant_en_s}};

  lh_rr_arbiter #(.N(NUM_SENSORS)) u_rr (
    .req_i     (req_s),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s),
    .any_gnt_o (any_gnt_s)
  );

  // Slot capture; a slot being granted this cycle is free to reload
  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    overflow_d   = overflow_q;
    drop_s       = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (sweep_strobe[i] && (!slot_valid_q[i] || gnt_s[i])) begin
        slot_d[i]       = {sync0[i*WIDTH +: WIDTH], sync1[i*WIDTH +: WIDTH],
                           sweep[i*WIDTH +: WIDTH]};
        slot_valid_d[i] = 1'b1;
      end else if (gnt_s[i]) begin
        slot_valid_d[i] = 1'b0;
      end else begin
        slot_valid_d[i] = slot_valid_q[i];
      end
      drop_s[i] = sweep_strobe[i] && slot_valid_q[i] && !gnt_s[i];
      if (drop_s[i]) begin
        overflow_d[i] = 1'b1;
      end else begin
        overflow_d[i] = overflow_q[i];
      end
    end
  end

  // Output register and round-robin pointer update
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (any_gnt_s) begin
      out_data_d  = {gnt_idx_s, slot_q[gnt_idx_s]};
      out_valid_d = 1'b1;
      rr_ptr_d    = lh_rr_idx(32'(gnt_idx_s), 32'd1, NUM_SENSORS);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers, synchronous reset
  always_ff @(posedge clk_48) begin
    if (reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        slot_q[i] <= '0;
      end
      slot_valid_q <= '0;
      overflow_q   <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      overflow_q   <= overflow_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

`ifdef LIGHTHOUSE_ARB_DROP_COUNT_EN
  logic [7:0] cnt_q [NUM_SENSORS];
  logic [7:0] cnt_d [NUM_SENSORS];

  // Saturating drop counters
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (drop_s[i] && (cnt_q[i] != 8'hFF)) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Drop counter registers
  always_ff @(posedge clk_48) begin
    if (reset) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_dc
    assign drop_count[g*8 +: 8] = cnt_q[g];
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_lighthouse_arbiter.sv
// Randomized and directed bench for lighthouse_arbiter against a behavioural record model.
module tb_lighthouse_arbiter;

  localparam int N     = 3;
  localparam int W     = 24;
  localparam int REC_W = 2 + 3 * W;

  logic               clk_48 = 1'b0;
  logic               reset;
  logic [N*W-1:0]     sync0, sync1, sweep;
  logic [N-1:0]       sweep_strobe;
  logic [REC_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       overflow;
  logic [N*8-1:0]     drop_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: pending records per channel, output record, pointer, drop tallies
  logic [3*W-1:0]   m_slot [N];
  logic [N-1:0]     m_sv;
  logic [REC_W-1:0] m_od;
  logic             m_ov;
  int               m_rr;
  logic [N-1:0]     m_ovf;
  int               m_cnt [N];

  always #10 clk_48 = ~clk_48;

  lighthouse_arbiter dut (
    .clk_48       (clk_48),
    .reset        (reset),
    .sync0        (sync0),
    .sync1        (sync1),
    .sweep        (sweep),
    .sweep_strobe (sweep_strobe),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_slot[i] = '0;
      m_cnt[i]  = 0;
    end
    m_sv  = '0;
    m_od  = '0;
    m_ov  = 1'b0;
    m_rr  = 0;
    m_ovf = '0;
  endtask

  // One clock of the arbitration rules, evaluated on pre-edge inputs
  task automatic model_step();
    int g;
    if (reset) begin
      model_clear();
      return;
    end
    g = -1;
    if (!m_ov || out_ready) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (g < 0 && m_sv[i]) g = i;
      end
    end
    if (g >= 0) begin
      m_od = {2'(g), m_slot[g]};
      m_ov = 1'b1;
      m_rr = (g + 1) % N;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (sweep_strobe[i]) begin
        if (!m_sv[i] || g == i) begin
          m_slot[i] = {sync0[i*W +: W], sync1[i*W +: W], sweep[i*W +: W]};
          m_sv[i]   = 1'b1;
        end else begin
          m_ovf[i] = 1'b1;
          if (m_cnt[i] < 255) m_cnt[i]++;
        end
      end else if (g == i) begin
        m_sv[i] = 1'b0;
      end
    end
  endtask

  function automatic logic [N*8-1:0] exp_drop_count();
    logic [N*8-1:0] v;
    v = '0;
`ifdef LIGHTHOUSE_ARB_DROP_COUNT_EN
    for (int i = 0; i < N; i++) v[i*8 +: 8] = 8'(m_cnt[i]);
`endif
    return v;
  endfunction

  // Advance one clock, then compare every output against the model
  task automatic cycle();
    @(posedge clk_48);
    model_step();
    #1;
    check_eq("out_valid", {127'd0, out_valid}, {127'd0, m_ov});
    check_eq("out_data", {54'd0, out_data}, {54'd0, m_od});
    check_eq("overflow", {125'd0, overflow}, {125'd0, m_ovf});
    check_eq("drop_count", {104'd0, drop_count}, {104'd0, exp_drop_count()});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sweep_strobe = '0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic rand_data();
    logic [31:0] a, b, c;
    for (int i = 0; i < N; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      sync0[i*W +: W] = a[W-1:0];
      sync1[i*W +: W] = b[W-1:0];
      sweep[i*W +: W] = c[W-1:0];
    end
  endtask

  initial begin
    logic [31:0] r;
    model_clear();
    reset = 1'b1;
    sync0 = '0; sync1 = '0; sweep = '0;
    sweep_strobe = '0;
    out_ready = 1'b1;
    cycle();
    cycle();
    check_eq("reset_valid", {127'd0, out_valid}, 128'd0);
    check_eq("reset_data", {54'd0, out_data}, 128'd0);
    reset = 1'b0;
    cycle();

    // Single uncontended record on channel 1
    sync0[1*W +: W] = 24'h000100;
    sync1[1*W +: W] = 24'h000200;
    sweep[1*W +: W] = 24'h001234;
    sweep_strobe = 3'b010;
    cycle();
    sweep_strobe = '0;
    check_eq("t1_not_yet", {127'd0, out_valid}, 128'd0);
    cycle();
    check_eq("t1_valid", {127'd0, out_valid}, 128'd1);
    check_eq("t1_data", {54'd0, out_data}, {54'd0, 2'd1, 24'h000100, 24'h000200, 24'h001234});
    cycle();
    check_eq("t1_one_cycle", {127'd0, out_valid}, 128'd0);

    // All channels together from pointer 0, then from pointer 2
    do_reset();
    rand_data();
    sweep_strobe = 3'b111;
    cycle();
    sweep_strobe = '0;
    cycle(); check_eq("t2_id_a", {126'd0, out_data[REC_W-1 -: 2]}, 128'd0);
    cycle(); check_eq("t2_id_b", {126'd0, out_data[REC_W-1 -: 2]}, 128'd1);
    cycle(); check_eq("t2_id_c", {126'd0, out_data[REC_W-1 -: 2]}, 128'd2);
    cycle();
    sweep_strobe = 3'b010;
    cycle();
    sweep_strobe = '0;
    cycle();
    cycle();
    rand_data();
    sweep_strobe = 3'b111;
    cycle();
    sweep_strobe = '0;
    cycle(); check_eq("t2_id_d", {126'd0, out_data[REC_W-1 -: 2]}, 128'd2);
    cycle(); check_eq("t2_id_e", {126'd0, out_data[REC_W-1 -: 2]}, 128'd0);
    cycle(); check_eq("t2_id_f", {126'd0, out_data[REC_W-1 -: 2]}, 128'd1);
    cycle();

    // Backpressure and overflow on channel 0
    do_reset();
    out_ready = 1'b0;
    rand_data();
    sweep_strobe = 3'b010;
    cycle();
    sweep_strobe = '0;
    cycle();
    cycle();
    rand_data(); sweep_strobe = 3'b001; cycle();
    rand_data(); sweep_strobe = 3'b001; cycle();
    sweep_strobe = '0;
    cycle();
    check_eq("t3_overflow0", {127'd0, overflow[0]}, 128'd1);
`ifdef LIGHTHOUSE_ARB_DROP_COUNT_EN
    check_eq("t3_drops0", {120'd0, drop_count[7:0]}, 128'd1);
`else
    check_eq("t3_drops0", {120'd0, drop_count[7:0]}, 128'd0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Channel 2 reloaded in the cycle its slot is granted
    do_reset();
    rand_data(); sweep_strobe = 3'b100; cycle();
    rand_data(); sweep_strobe = 3'b100; cycle();
    sweep_strobe = '0;
    cycle();
    cycle();
    check_eq("t4_no_drop", {125'd0, overflow}, 128'd0);

    // Reset while output valid and slots pending
    do_reset();
    out_ready = 1'b0;
    rand_data(); sweep_strobe = 3'b111; cycle();
    sweep_strobe = '0;
    cycle();
    rand_data(); sweep_strobe = 3'b011; cycle();
    sweep_strobe = '0;
    do_reset();
    check_eq("t5_valid", {127'd0, out_valid}, 128'd0);
    check_eq("t5_overflow", {125'd0, overflow}, 128'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("t5_no_stale", {127'd0, out_valid}, 128'd0);

    // Many drops on channel 1: counter saturates
    do_reset();
    out_ready = 1'b0;
    sweep_strobe = 3'b010;
    for (int i = 0; i < 310; i++) begin
      rand_data();
      cycle();
    end
    sweep_strobe = '0;
    cycle();
`ifdef LIGHTHOUSE_ARB_DROP_COUNT_EN
    check_eq("t6_saturate", {120'd0, drop_count[15:8]}, 128'hFF);
`else
    check_eq("t6_saturate", {120'd0, drop_count[15:8]}, 128'd0);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic with varying strobe density and sink readiness
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rand_data();
      r = $urandom;
      sweep_strobe = (r[1:0] == 2'd0) ? 3'b000 : r[4:2];
      case (c / 500)
        0:       out_ready = 1'b1;
        1:       out_ready = (r[7:5] != 3'd0);
        2:       out_ready = (r[7:5] == 3'd0);
        default: out_ready = r[8];
      endcase
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;
    sweep_strobe = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
